// File: rtl/prog_mem_loader.sv
// Loads a program image from a valid/ready word stream into the CPU's external
// memory write port, holding the CPU in reset until the image is in place.
module prog_mem_loader #(
  parameter int          NUM_WORDS  = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RESET_HOLD = 4,
  localparam int         CW         = $clog2(NUM_WORDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic          Ext_MemWrite,
  output logic [31:0]   Ext_DataAdr,
  output logic [31:0]   Ext_WriteData,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] word_count
);

  localparam int HW = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} loaderState;

  loaderState    stateReg, stateNext;
  logic [HW-1:0] holdCntReg;
  logic          handshake;
  logic          restart;

  assign in_ready  = (stateReg == LOAD);
  assign busy      = (stateReg == LOAD) || (stateReg == HOLD);
  assign done      = (stateReg == RUN);
  assign handshake = in_valid && in_ready;
  assign restart   = start && ((stateReg == IDLE) || (stateReg == RUN));

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (start) stateNext = LOAD;
      LOAD: if (handshake && (word_count == CW'(NUM_WORDS - 1))) stateNext = HOLD;
      // First HOLD cycle carries the last write pulse; leave after RESET_HOLD cycles.
      HOLD: if (holdCntReg == HW'(RESET_HOLD - 1)) stateNext = RUN;
      RUN:  if (start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg      <= IDLE;
      holdCntReg    <= '0;
      cpu_reset     <= 1'b1;
      Ext_MemWrite  <= 1'b0;
      Ext_DataAdr   <= 32'h0;
      Ext_WriteData <= 32'h0;
      word_count    <= '0;
    end else begin
      stateReg     <= stateNext;
      // Registered from the next state so the CPU leaves reset on the first RUN cycle.
      cpu_reset    <= (stateNext != RUN);
      Ext_MemWrite <= handshake;
      holdCntReg   <= (stateReg == HOLD) ? holdCntReg + 1'b1 : '0;
      if (handshake) begin
        Ext_DataAdr   <= BASE_ADDR + (32'(word_count) << 2);
        Ext_WriteData <= in_data;
        word_count    <= word_count + 1'b1;
      end else if (restart) begin
        word_count <= '0;
      end
    end
  end

endmodule
